axi_mm_burst_to_fifo: RTL

AXI_MM_BURST_TO_FIFO -- requirements
Module: axi_mm_burst_to_fifo

---
 rtl/axi_mm_dma_pkg.sv | 20 ++
 rtl/axi_burst_len_calc.sv | 64 ++++++
 rtl/axi_mm_burst_to_fifo.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/axi_mm_dma_pkg.sv
// Shared types and constants for the AXI memory-mapped burst reader.
// Optional build macro: AXI_4K_SPLIT_EN (see axi_burst_len_calc).
package axi_mm_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CALC       = 3'd1,
        ST_SEND_AR    = 3'd2,
        ST_READ_BURST = 3'd3,
        ST_FINISH     = 3'd4
    } dma_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_MAX_BEATS  = 256;

    // Wide enough to hold a beat count of AXI_MAX_BEATS.
    localparam int         BEAT_WIDTH     = $clog2(AXI_MAX_BEATS) + 1;

endpackage

// File: rtl/axi_burst_len_calc.sv
// Combinational burst sizing: beats = min(remaining, MAX_BURST_LEN), and with
// AXI_4K_SPLIT_EN defined, further limited so the burst ends at or before the
// next 4 KiB page boundary.
module axi_burst_len_calc
    import axi_mm_dma_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int LEN_WIDTH     = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [LEN_WIDTH-1:0]  remaining,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [BEAT_WIDTH-1:0] beats
);

    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam logic [BEAT_WIDTH-1:0] MAX_BEATS_C = BEAT_WIDTH'(MAX_BURST_LEN);

    logic [BEAT_WIDTH-1:0] len_beats_s;
    logic [12:0]           page_room_s;
    logic [12:0]           room_beats_s;
    logic                  unused_addr_s;

    // Only the in-page offset matters for the boundary clamp.
    assign unused_addr_s = ^addr[ADDR_WIDTH-1:12];

    // Limit the burst to the words still owed and to the configured maximum.
    always_comb begin
        len_beats_s = MAX_BEATS_C;
        if (remaining < LEN_WIDTH'(MAX_BURST_LEN)) begin
            len_beats_s = BEAT_WIDTH'(remaining);
        end else begin
            len_beats_s = MAX_BEATS_C;
        end
    end

    // Beats that fit between the current address and the next 4 KiB page.
    always_comb begin
        page_room_s  = 13'd4096 - {1'b0, addr[11:0]};
        room_beats_s = page_room_s / 13'(BYTES_PER_BEAT);
    end

`ifdef AXI_4K_SPLIT_EN
    // Keep the burst inside the current page.
    always_comb begin
        beats = len_beats_s;
        if ({4'd0, len_beats_s} > room_beats_s) begin
            beats = room_beats_s[BEAT_WIDTH-1:0];
        end else begin
            beats = len_beats_s;
        end
    end
`else
    logic unused_room_s;
    assign unused_room_s = ^room_beats_s;

    // No page clamp in this build.
    always_comb begin
        beats = len_beats_s;
    end
`endif

endmodule

// File: rtl/axi_mm_burst_to_fifo.sv
// Reads TRANSFER_LEN words from AXI memory starting at BASE_ADDR, issuing one
// INCR burst at a time, and streams the read data straight into a FIFO.
// Optional build macro: AXI_4K_SPLIT_EN keeps bursts inside 4 KiB pages.
module axi_mm_burst_to_fifo
    import axi_mm_dma_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 16,
    parameter int LEN_WIDTH     = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [LEN_WIDTH-1:0]  TRANSFER_LEN,
    input  logic                  START,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  fifo_wren,
    input  logic                  fifo_full,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int         BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam logic [2:0] AXI_SIZE_C     = 3'($clog2(BYTES_PER_BEAT));

    dma_state_e            state_r;
    dma_state_e            next_state_s;
    logic                  start_prev_r;
    logic                  start_edge_s;
    logic [ADDR_WIDTH-1:0] araddr_r;
    logic [LEN_WIDTH-1:0]  remaining_r;
    logic [BEAT_WIDTH-1:0] beats_r;
    logic [BEAT_WIDTH-1:0] beat_cnt_r;
    logic [BEAT_WIDTH-1:0] calc_beats_s;
    logic [7:0]            arlen_r;
    logic                  arvalid_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;
    logic                  rready_s;
    logic                  wren_s;
    logic                  beat_accept_s;
    logic                  last_beat_s;
    logic                  more_s;

    assign start_edge_s  = START & ~start_prev_r;
    assign beat_accept_s = (state_r == ST_READ_BURST) & m_axi_rvalid & ~fifo_full;
    assign last_beat_s   = (beat_cnt_r == (beats_r - BEAT_WIDTH'(1)));
    assign more_s        = (remaining_r != LEN_WIDTH'(beats_r));

    axi_burst_len_calc #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .LEN_WIDTH     (LEN_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_len_calc (
        .remaining (remaining_r),
        .addr      (araddr_r),
        .beats     (calc_beats_s)
    );

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and the zero-latency R-channel to FIFO pass-through.
    always_comb begin
        next_state_s = state_r;
        rready_s     = 1'b0;
        wren_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    if (TRANSFER_LEN == {LEN_WIDTH{1'b0}}) begin
                        next_state_s = ST_FINISH;
                    end else begin
                        next_state_s = ST_CALC;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                next_state_s = ST_SEND_AR;
            end
            ST_SEND_AR: begin
                if (m_axi_arready) begin
                    next_state_s = ST_READ_BURST;
                end else begin
                    next_state_s = ST_SEND_AR;
                end
            end
            ST_READ_BURST: begin
                rready_s = ~fifo_full;
                wren_s   = beat_accept_s;
                if (beat_accept_s && last_beat_s) begin
                    next_state_s = more_s ? ST_CALC : ST_FINISH;
                end else begin
                    next_state_s = ST_READ_BURST;
                end
            end
            ST_FINISH: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Transfer bookkeeping, burst parameters, status and registered outputs.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            start_prev_r <= 1'b0;
            araddr_r     <= {ADDR_WIDTH{1'b0}};
            remaining_r  <= {LEN_WIDTH{1'b0}};
            beats_r      <= {BEAT_WIDTH{1'b0}};
            beat_cnt_r   <= {BEAT_WIDTH{1'b0}};
            arlen_r      <= 8'd0;
            arvalid_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            start_prev_r <= START;
            busy_r       <= (next_state_s != ST_IDLE);
            done_r       <= (state_r == ST_FINISH);
            arvalid_r    <= (next_state_s == ST_SEND_AR);
            case (state_r)
                ST_IDLE: begin
                    if (start_edge_s) begin
                        araddr_r    <= BASE_ADDR;
                        remaining_r <= TRANSFER_LEN;
                        beat_cnt_r  <= {BEAT_WIDTH{1'b0}};
                        error_r     <= 1'b0;
                    end
                end
                ST_CALC: begin
                    beats_r    <= calc_beats_s;
                    arlen_r    <= 8'(calc_beats_s - BEAT_WIDTH'(1));
                    beat_cnt_r <= {BEAT_WIDTH{1'b0}};
                end
                ST_READ_BURST: begin
                    if (beat_accept_s) begin
                        // A bad response or misplaced rlast is flagged but the
                        // beat is still delivered; the beat count ends the burst.
                        if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != last_beat_s)) begin
                            error_r <= 1'b1;
                        end
                        if (last_beat_s) begin
                            araddr_r    <= araddr_r + (ADDR_WIDTH'(beats_r) * ADDR_WIDTH'(BYTES_PER_BEAT));
                            remaining_r <= remaining_r - LEN_WIDTH'(beats_r);
                            beat_cnt_r  <= {BEAT_WIDTH{1'b0}};
                        end else begin
                            beat_cnt_r  <= beat_cnt_r + BEAT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign BUSY          = busy_r;
    assign DONE          = done_r;
    assign ERROR         = error_r;
    assign fifo_wdata    = m_axi_rdata;
    assign fifo_wren     = wren_s;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arlen   = arlen_r;
    assign m_axi_arsize  = AXI_SIZE_C;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_s;

endmodule
